// File: rtl/axi_s_mem.sv
// AXI slave memory model serving 4-beat cache-line bursts from a word-addressed RAM.
// Write (AW/W/B) and read (AR/R) run as independent FSMs over one write port and one read port.
module axi_s_mem #(
   parameter logic [31:0] SLV_ADDR_BASE = 32'h0000_0000,
   parameter int          MEM_DEPTH     = 1024,
   parameter int          WIDTH_ID      = 1,
   parameter int          WIDTH_AD      = 32,
   parameter int          WIDTH_DA      = 32
) (
   input  logic                  S_AXI_ACLK,
   input  logic                  S_AXI_ARESETN,
   input  logic [WIDTH_ID-1:0]   S_AXI_AWID,
   input  logic [WIDTH_AD-1:0]   S_AXI_AWADDR,
   input  logic [3:0]            S_AXI_AWLEN,
   input  logic [2:0]            S_AXI_AWSIZE,
   input  logic [1:0]            S_AXI_AWBURST,
   input  logic                  S_AXI_AWVALID,
   output logic                  S_AXI_AWREADY,
   input  logic [WIDTH_DA-1:0]   S_AXI_WDATA,
   input  logic [WIDTH_DA/8-1:0] S_AXI_WSTRB,
   input  logic                  S_AXI_WLAST,
   input  logic                  S_AXI_WVALID,
   output logic                  S_AXI_WREADY,
   output logic [WIDTH_ID-1:0]   S_AXI_BID,
   output logic [1:0]            S_AXI_BRESP,
   output logic                  S_AXI_BVALID,
   input  logic                  S_AXI_BREADY,
   input  logic [WIDTH_ID-1:0]   S_AXI_ARID,
   input  logic [WIDTH_AD-1:0]   S_AXI_ARADDR,
   input  logic [3:0]            S_AXI_ARLEN,
   input  logic [2:0]            S_AXI_ARSIZE,
   input  logic [1:0]            S_AXI_ARBURST,
   input  logic                  S_AXI_ARVALID,
   output logic                  S_AXI_ARREADY,
   output logic [WIDTH_ID-1:0]   S_AXI_RID,
   output logic [WIDTH_DA-1:0]   S_AXI_RDATA,
   output logic [1:0]            S_AXI_RRESP,
   output logic                  S_AXI_RLAST,
   output logic                  S_AXI_RVALID,
   input  logic                  S_AXI_RREADY
);

   localparam int         IDX_W       = $clog2(MEM_DEPTH);
   localparam int         NB          = WIDTH_DA / 8;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

   function automatic logic f_in_range(input logic [WIDTH_AD-1:0] a);
      logic [WIDTH_AD-1:0] off;
      off = a - WIDTH_AD'(SLV_ADDR_BASE);
      return (a >= WIDTH_AD'(SLV_ADDR_BASE)) && ((off >> 2) < WIDTH_AD'(MEM_DEPTH));
   endfunction

   function automatic logic [IDX_W-1:0] f_idx(input logic [WIDTH_AD-1:0] a);
      return IDX_W'((a - WIDTH_AD'(SLV_ADDR_BASE)) >> 2);
   endfunction

   // WRAP is treated as INCR; only FIXED holds the address.
   function automatic logic [WIDTH_AD-1:0] f_step(input logic [WIDTH_AD-1:0] a,
                                                  input logic [1:0]          burst);
      return (burst == 2'b00) ? a : a + WIDTH_AD'(4);
   endfunction

   logic [WIDTH_DA-1:0] r_mem [MEM_DEPTH];

   w_state_t            r_w_state, w_w_next;
   logic [WIDTH_ID-1:0] r_awid;
   logic [WIDTH_AD-1:0] r_waddr;
   logic [3:0]          r_awlen, r_wcnt;
   logic [1:0]          r_awburst, r_bresp;
   logic                r_dec_err, r_last_err;
   logic                w_awready, w_wready, w_bvalid;
   logic                w_w_final, w_w_in, w_wlast_bad, w_mem_we;

   assign w_w_final   = (r_wcnt == r_awlen);
   assign w_w_in      = f_in_range(r_waddr);
   assign w_wlast_bad = (S_AXI_WLAST != w_w_final);
   assign w_mem_we    = S_AXI_ARESETN && (r_w_state == W_DATA) && S_AXI_WVALID && w_w_in;

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      w_w_next  = r_w_state;
      w_awready = 1'b0;
      w_wready  = 1'b0;
      w_bvalid  = 1'b0;
      case (r_w_state)
         W_IDLE: begin
            w_awready = 1'b1;
            if (S_AXI_AWVALID) w_w_next = W_DATA;
         end
         W_DATA: begin
            w_wready = 1'b1;
            if (S_AXI_WVALID && w_w_final) w_w_next = W_RESP;
         end
         W_RESP: begin
            w_bvalid = 1'b1;
            if (S_AXI_BREADY) w_w_next = W_IDLE;
         end
         default: w_w_next = W_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         r_w_state  <= W_IDLE;
         r_awid     <= '0;
         r_waddr    <= '0;
         r_awlen    <= '0;
         r_awburst  <= '0;
         r_wcnt     <= '0;
         r_dec_err  <= 1'b0;
         r_last_err <= 1'b0;
         r_bresp    <= RESP_OKAY;
      end else begin
         r_w_state <= w_w_next;
         case (r_w_state)
            W_IDLE: if (S_AXI_AWVALID) begin
               r_awid     <= S_AXI_AWID;
               r_waddr    <= S_AXI_AWADDR;
               r_awlen    <= S_AXI_AWLEN;
               r_awburst  <= S_AXI_AWBURST;
               r_wcnt     <= '0;
               r_dec_err  <= 1'b0;
               r_last_err <= 1'b0;
            end
            W_DATA: if (S_AXI_WVALID) begin
               r_waddr <= f_step(r_waddr, r_awburst);
               r_wcnt  <= r_wcnt + 4'd1;
               if (!w_w_in)     r_dec_err  <= 1'b1;
               if (w_wlast_bad) r_last_err <= 1'b1;
               // The response folds in the flags raised by this final beat as well.
               if (w_w_final)
                  r_bresp <= (r_dec_err || !w_w_in)        ? RESP_DECERR :
                             (r_last_err || w_wlast_bad)   ? RESP_SLVERR : RESP_OKAY;
            end
            W_RESP: if (S_AXI_BREADY) r_bresp <= RESP_OKAY;
            default: ;
         endcase
      end
   end

   // NOTE: the RAM array is deliberately not reset; contents persist across reset.
   always_ff @(posedge S_AXI_ACLK) begin
      if (w_mem_we)
         for (int b = 0; b < NB; b++)
            if (S_AXI_WSTRB[b]) r_mem[f_idx(r_waddr)][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
   end

   r_state_t            r_r_state, w_r_next;
   logic [WIDTH_ID-1:0] r_arid;
   logic [WIDTH_AD-1:0] r_raddr;
   logic [3:0]          r_arlen, r_rcnt;
   logic [1:0]          r_arburst, r_rresp;
   logic [WIDTH_DA-1:0] r_rdata;
   logic                r_rlast;
   logic                w_arready, w_rvalid, w_r_in;
   logic [WIDTH_AD-1:0] w_r_addr;
   logic [WIDTH_DA-1:0] w_r_word;

   // The beat being loaded comes from ARADDR on acceptance, else from the stepped address.
   assign w_r_addr = (r_r_state == R_IDLE) ? S_AXI_ARADDR : r_raddr;
   assign w_r_in   = f_in_range(w_r_addr);
   assign w_r_word = r_mem[f_idx(w_r_addr)];

   always_comb begin
      w_r_next  = r_r_state;
      w_arready = 1'b0;
      w_rvalid  = 1'b0;
      case (r_r_state)
         R_IDLE: begin
            w_arready = 1'b1;
            if (S_AXI_ARVALID) w_r_next = R_DATA;
         end
         R_DATA: begin
            w_rvalid = 1'b1;
            if (S_AXI_RREADY && r_rlast) w_r_next = R_IDLE;
         end
         default: w_r_next = R_IDLE;
      endcase
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         r_r_state <= R_IDLE;
         r_arid    <= '0;
         r_raddr   <= '0;
         r_arlen   <= '0;
         r_arburst <= '0;
         r_rcnt    <= '0;
         r_rdata   <= '0;
         r_rresp   <= RESP_OKAY;
         r_rlast   <= 1'b0;
      end else begin
         r_r_state <= w_r_next;
         case (r_r_state)
            R_IDLE: if (S_AXI_ARVALID) begin
               r_arid    <= S_AXI_ARID;
               r_arlen   <= S_AXI_ARLEN;
               r_arburst <= S_AXI_ARBURST;
               r_raddr   <= f_step(S_AXI_ARADDR, S_AXI_ARBURST);
               r_rcnt    <= '0;
               r_rdata   <= w_r_in ? w_r_word : '0;
               r_rresp   <= w_r_in ? RESP_OKAY : RESP_DECERR;
               r_rlast   <= (S_AXI_ARLEN == 4'd0);
            end
            R_DATA: if (S_AXI_RREADY) begin
               if (r_rlast) begin
                  r_rlast <= 1'b0;
               end else begin
                  r_raddr <= f_step(r_raddr, r_arburst);
                  r_rcnt  <= r_rcnt + 4'd1;
                  r_rdata <= w_r_in ? w_r_word : '0;
                  r_rresp <= w_r_in ? RESP_OKAY : RESP_DECERR;
                  r_rlast <= ((r_rcnt + 4'd1) == r_arlen);
               end
            end
            default: ;
         endcase
      end
   end

   logic w_unused_ok;
   assign w_unused_ok = ^{S_AXI_AWSIZE, S_AXI_ARSIZE};

   assign S_AXI_AWREADY = w_awready;
   assign S_AXI_WREADY  = w_wready;
   assign S_AXI_BVALID  = w_bvalid;
   assign S_AXI_BID     = r_awid;
   assign S_AXI_BRESP   = r_bresp;
   assign S_AXI_ARREADY = w_arready;
   assign S_AXI_RVALID  = w_rvalid;
   assign S_AXI_RID     = r_arid;
   assign S_AXI_RDATA   = r_rdata;
   assign S_AXI_RRESP   = r_rresp;
   assign S_AXI_RLAST   = r_rlast;

endmodule

// File: tb/tb_axi_s_mem.sv
// Scoreboard bench for axi_s_mem: directed bursts push expected B/R responses,
// negedge monitors pop and compare on every handshake.
module tb_axi_s_mem;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [0:0]  awid, arid, bid, rid;
   logic [31:0] awaddr, araddr, wdata, rdata;
   logic [3:0]  awlen, arlen, wstrb;
   logic [2:0]  awsize, arsize;
   logic [1:0]  awburst, arburst, bresp, rresp;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rlast, rvalid, rready;

   localparam logic [1:0] INCR = 2'b01, FIXED = 2'b00;
   localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

   axi_s_mem dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
      .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize),
      .S_AXI_AWBURST(awburst), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WVALID(wvalid),
      .S_AXI_WREADY(wready),
      .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize),
      .S_AXI_ARBURST(arburst), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
      .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
   );

   always #5 clk = ~clk;

   typedef struct { logic [0:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;
   typedef struct { logic [0:0] id; logic [1:0] resp; } b_exp_t;

   r_exp_t      rq[$];
   b_exp_t      bq[$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] wd[16];
   logic [3:0]  ws[16];
   logic        wl[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Read-channel monitor: compare on handshake, check hold against the pending beat on stall.
   always @(negedge clk) begin : mon_r
      r_exp_t e;
      if (rvalid === 1'b1 && rready === 1'b1) begin
         if (rq.size() == 0) begin
            check("r_unexpected_beat", 32'(rq.size()), 32'd1);
         end else begin
            e = rq.pop_front();
            check("r_data", rdata, e.data);
            check("r_resp", 32'(rresp), 32'(e.resp));
            check("r_last", 32'(rlast), 32'(e.last));
            check("r_id",   32'(rid),   32'(e.id));
         end
      end else if (rvalid === 1'b1 && rq.size() > 0) begin
         check("r_hold_data", rdata, rq[0].data);
         check("r_hold_last", 32'(rlast), 32'(rq[0].last));
      end
   end

   always @(negedge clk) begin : mon_b
      b_exp_t e;
      if (bvalid === 1'b1 && bready === 1'b1) begin
         if (bq.size() == 0) begin
            check("b_unexpected", 32'(bq.size()), 32'd1);
         end else begin
            e = bq.pop_front();
            check("b_resp", 32'(bresp), 32'(e.resp));
            check("b_id",   32'(bid),   32'(e.id));
         end
      end
   end

   task automatic push_r(input logic [0:0] id, input logic [31:0] d, input logic [1:0] resp,
                         input logic last);
      r_exp_t e;
      e.id = id; e.data = d; e.resp = resp; e.last = last;
      rq.push_back(e);
   endtask

   task automatic do_aw(input logic [0:0] id, input logic [31:0] addr, input logic [3:0] len,
                        input logic [1:0] burst);
      int n = 0;
      awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = 3'd2; awvalid = 1'b1;
      do begin @(negedge clk); n++; end while (awready !== 1'b1 && n < 100);
      check("aw_handshake", 32'(awready), 32'd1);
      @(posedge clk); #1 awvalid = 1'b0;
   endtask

   task automatic do_ar(input logic [0:0] id, input logic [31:0] addr, input logic [3:0] len,
                        input logic [1:0] burst);
      int n = 0;
      arid = id; araddr = addr; arlen = len; arburst = burst; arsize = 3'd2; arvalid = 1'b1;
      do begin @(negedge clk); n++; end while (arready !== 1'b1 && n < 100);
      check("ar_handshake", 32'(arready), 32'd1);
      @(posedge clk); #1 arvalid = 1'b0;
      check("r_first_latency", 32'(rvalid), 32'd1);
      check("ar_busy", 32'(arready), 32'd0);
   endtask

   task automatic do_w(input int n);
      for (int i = 0; i < n; i++) begin
         int c = 0;
         wdata = wd[i]; wstrb = ws[i]; wlast = wl[i]; wvalid = 1'b1;
         do begin @(negedge clk); c++; end while (wready !== 1'b1 && c < 100);
         check("w_ready", 32'(wready), 32'd1);
         @(posedge clk); #1;
      end
      wvalid = 1'b0; wlast = 1'b0;
   endtask

   task automatic do_b(input logic [0:0] id, input logic [1:0] resp, input int hold);
      b_exp_t e;
      int n = 0;
      e.id = id; e.resp = resp;
      bq.push_back(e);
      do begin @(negedge clk); n++; end while (bvalid !== 1'b1 && n < 100);
      check("b_valid", 32'(bvalid), 32'd1);
      for (int i = 0; i < hold; i++) begin
         check("b_hold_valid", 32'(bvalid), 32'd1);
         check("b_hold_resp", 32'(bresp), 32'(resp));
         check("aw_blocked", 32'(awready), 32'd0);
         @(negedge clk);
      end
      @(posedge clk); #1 bready = 1'b1;
      @(posedge clk); #1 bready = 1'b0;
      check("b_done", 32'(bvalid), 32'd0);
      check("aw_reopen", 32'(awready), 32'd1);
   endtask

   // mode 0: RREADY always high; mode 1: RREADY pattern 1,0,0,1 repeating.
   task automatic collect(input int n, input int mode);
      int got = 0;
      int cyc = 0;
      while (got < n && cyc < 200) begin
         rready = (mode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
         @(negedge clk);
         if (rvalid === 1'b1 && rready === 1'b1) got++;
         @(posedge clk); #1;
         cyc++;
      end
      rready = 1'b0;
      check("r_beat_count", 32'(got), 32'(n));
      if (mode == 0) check("r_no_bubble", 32'(cyc), 32'(n));
      check("ar_idle", 32'(arready), 32'd1);
   endtask

   task automatic wr_burst(input logic [0:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input logic [3:0] strb, input int last_beat,
                           input logic [1:0] resp, input int hold);
      for (int i = 0; i <= int'(len); i++) begin
         ws[i] = strb;
         wl[i] = (i == last_beat);
      end
      do_aw(id, addr, len, burst);
      do_w(int'(len) + 1);
      do_b(id, resp, hold);
   endtask

   task automatic rd_burst(input logic [0:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input int mode);
      do_ar(id, addr, len, burst);
      collect(int'(len) + 1, mode);
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
      arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
      rready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_awready", 32'(awready), 32'd1);
      check("rst_arready", 32'(arready), 32'd1);
      check("rst_wready",  32'(wready),  32'd0);
      check("rst_bvalid",  32'(bvalid),  32'd0);
      check("rst_rvalid",  32'(rvalid),  32'd0);
      check("rst_rlast",   32'(rlast),   32'd0);
      check("rst_rdata",   rdata,        32'd0);
      check("rst_bresp",   32'(bresp),   32'd0);
      @(posedge clk); #1 rst_n = 1'b1;

      // Basic 4-beat write with 5 cycles of B backpressure, then read back.
      wd[0] = 32'h11111111; wd[1] = 32'h22222222; wd[2] = 32'h33333333; wd[3] = 32'h44444444;
      wr_burst(1'b1, 32'h40, 4'd3, INCR, 4'hF, 3, OKAY, 5);
      push_r(1'b1, 32'h11111111, OKAY, 1'b0); push_r(1'b1, 32'h22222222, OKAY, 1'b0);
      push_r(1'b1, 32'h33333333, OKAY, 1'b0); push_r(1'b1, 32'h44444444, OKAY, 1'b1);
      rd_burst(1'b1, 32'h40, 4'd3, INCR, 0);

      // Same read with RREADY stalls.
      push_r(1'b0, 32'h11111111, OKAY, 1'b0); push_r(1'b0, 32'h22222222, OKAY, 1'b0);
      push_r(1'b0, 32'h33333333, OKAY, 1'b0); push_r(1'b0, 32'h44444444, OKAY, 1'b1);
      rd_burst(1'b0, 32'h40, 4'd3, INCR, 1);

      // Byte strobes.
      wd[0] = 32'h44332211;
      wr_burst(1'b0, 32'h40, 4'd0, INCR, 4'hF, 0, OKAY, 0);
      wd[0] = 32'hAABBCCDD;
      wr_burst(1'b0, 32'h40, 4'd0, INCR, 4'b0101, 0, OKAY, 0);
      push_r(1'b0, 32'h44BB22DD, OKAY, 1'b1);
      rd_burst(1'b0, 32'h40, 4'd0, INCR, 0);

      // Burst running off the top of memory.
      wd[0] = 32'hA1A1A1A1; wd[1] = 32'hA2A2A2A2; wd[2] = 32'hA3A3A3A3; wd[3] = 32'hA4A4A4A4;
      wr_burst(1'b1, 32'hFF8, 4'd3, INCR, 4'hF, 3, DECERR, 0);
      push_r(1'b1, 32'hA1A1A1A1, OKAY, 1'b0); push_r(1'b1, 32'hA2A2A2A2, OKAY, 1'b0);
      push_r(1'b1, 32'h0, DECERR, 1'b0);      push_r(1'b1, 32'h0, DECERR, 1'b1);
      rd_burst(1'b1, 32'hFF8, 4'd3, INCR, 0);

      // Early WLAST, then missing WLAST.
      wd[0] = 32'h10000001; wd[1] = 32'h10000002; wd[2] = 32'h10000003; wd[3] = 32'h10000004;
      wr_burst(1'b0, 32'h100, 4'd3, INCR, 4'hF, 1, SLVERR, 0);
      push_r(1'b0, 32'h10000001, OKAY, 1'b0); push_r(1'b0, 32'h10000002, OKAY, 1'b0);
      push_r(1'b0, 32'h10000003, OKAY, 1'b0); push_r(1'b0, 32'h10000004, OKAY, 1'b1);
      rd_burst(1'b0, 32'h100, 4'd3, INCR, 0);
      wd[0] = 32'h20000001; wd[1] = 32'h20000002;
      wr_burst(1'b1, 32'h110, 4'd1, INCR, 4'hF, 99, SLVERR, 0);

      // FIXED burst: both beats land in and return from one word.
      wd[0] = 32'hD0D0D0D0; wd[1] = 32'hD1D1D1D1;
      wr_burst(1'b1, 32'h200, 4'd1, FIXED, 4'hF, 1, OKAY, 0);
      push_r(1'b1, 32'hD1D1D1D1, OKAY, 1'b0); push_r(1'b1, 32'hD1D1D1D1, OKAY, 1'b1);
      rd_burst(1'b1, 32'h200, 4'd1, FIXED, 0);

      // AW and AR on the same edge; read of 0x80 coincides with its write.
      wd[0] = 32'h0BADBEEF; wd[1] = 32'hCAFEF00D;
      wr_burst(1'b0, 32'h7C, 4'd1, INCR, 4'hF, 1, OKAY, 0);
      push_r(1'b1, 32'h0BADBEEF, OKAY, 1'b0); push_r(1'b1, 32'hCAFEF00D, OKAY, 1'b1);
      wd[0] = 32'h12345678; ws[0] = 4'hF; wl[0] = 1'b1;
      fork
         begin do_aw(1'b1, 32'h80, 4'd0, INCR); do_w(1); do_b(1'b1, OKAY, 0); end
         begin do_ar(1'b1, 32'h7C, 4'd1, INCR); collect(2, 0); end
      join
      push_r(1'b0, 32'h12345678, OKAY, 1'b1);
      rd_burst(1'b0, 32'h80, 4'd0, INCR, 0);

      // Reset while beat 2 of a read is presented.
      push_r(1'b0, 32'h10000001, OKAY, 1'b0);
      do_ar(1'b0, 32'h100, 4'd3, INCR);
      rready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1 rready = 1'b0; rst_n = 1'b0;
      @(posedge clk); #1;
      check("rst_mid_rvalid",  32'(rvalid),  32'd0);
      check("rst_mid_arready", 32'(arready), 32'd1);
      check("rst_mid_rlast",   32'(rlast),   32'd0);
      rst_n = 1'b1;
      push_r(1'b0, 32'h10000001, OKAY, 1'b0); push_r(1'b0, 32'h10000002, OKAY, 1'b0);
      push_r(1'b0, 32'h10000003, OKAY, 1'b0); push_r(1'b0, 32'h10000004, OKAY, 1'b1);
      rd_burst(1'b0, 32'h100, 4'd3, INCR, 0);

      repeat (5) @(posedge clk);
      check("r_queue_empty", 32'(rq.size()), 32'd0);
      check("b_queue_empty", 32'(bq.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
